tile_grid_ctrl: RTL and testbench



---
 rtl/tile_grid_pkg.sv | 28 ++
 rtl/tile_grid_ctrl_edge_pulse.sv | 34 +++
 rtl/tile_grid_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_tile_grid_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_grid_pkg.sv
// -----------------------------------------------------------------------------
// tile_grid_pkg
// Shared types and helpers for the tile grid controller.
//   state_e   : select/swap FSM states (IDLE, SEL, SWAP)
//   init_type : reset tile-type pattern, (r*cols + c) mod ntypes
//   ROW_W/COL_W : coordinate widths of the default 3x3 grid
// Optional feature macro used by the top level: TILE_GRID_ADJ_ONLY_EN.
// -----------------------------------------------------------------------------
package tile_grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_SWAP = 2'd2
    } state_e;

    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 3;
    localparam int ROW_W    = $clog2(DEF_ROWS);
    localparam int COL_W    = $clog2(DEF_COLS);

    // Reset pattern: types cycle through the grid in row-major order.
    function automatic int init_type(input int r, input int c,
                                     input int cols, input int ntypes);
        return (r * cols + c) % ntypes;
    endfunction

endpackage

// File: rtl/tile_grid_ctrl_edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// Registers one synchronised button level and flags its rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : debounced button level
//   pulse_o    : high for the one cycle where btn_i is 1 and was 0 before
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic btn_q;
    logic btn_d;

    // History register input.
    always_comb begin
        btn_d = btn_i;
    end

    // Previous-level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign pulse_o = btn_i & ~btn_q;

endmodule

// File: rtl/tile_grid_ctrl.sv
// -----------------------------------------------------------------------------
// tile_grid_ctrl
// ROWS x COLS tile-type matrix with a tile cursor and a two-click select/swap
// FSM. The first selected tile flashes with a FLASH_DIV-cycle half period.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   btn_up/down/left/right, btn_click  : debounced button levels
//   rd_row, rd_col -> rd_type, rd_blank: combinational renderer read port
//   cur_row, cur_col                   : cursor position
//   sel_valid, sel_row, sel_col        : first selected tile
//   swap_done                          : one-cycle pulse on a committed swap
// Optional feature: define TILE_GRID_ADJ_ONLY_EN to allow swaps only between
// orthogonally adjacent tiles; a distant click moves the selection instead.
// -----------------------------------------------------------------------------
module tile_grid_ctrl
    import tile_grid_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int TYPE_W    = 2,
    parameter int NUM_TYPES = 4,
    parameter int FLASH_DIV = 6250000,
    // Local widths for this instance's grid (take precedence over the package defaults).
    localparam int ROW_W    = $clog2(ROWS),
    localparam int COL_W    = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_click,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [TYPE_W-1:0] rd_type,
    output logic              rd_blank,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              sel_valid,
    output logic [ROW_W-1:0]  sel_row,
    output logic [COL_W-1:0]  sel_col,
    output logic              swap_done
);

    localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic up_e, down_e, left_e, right_e, click_e;

    edge_pulse u_up    (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),    .pulse_o(up_e));
    edge_pulse u_down  (.clk(clk), .rst_n(rst_n), .btn_i(btn_down),  .pulse_o(down_e));
    edge_pulse u_left  (.clk(clk), .rst_n(rst_n), .btn_i(btn_left),  .pulse_o(left_e));
    edge_pulse u_right (.clk(clk), .rst_n(rst_n), .btn_i(btn_right), .pulse_o(right_e));
    edge_pulse u_click (.clk(clk), .rst_n(rst_n), .btn_i(btn_click), .pulse_o(click_e));

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   cur_row_q, cur_row_d, sel_row_q, sel_row_d, sec_row_q, sec_row_d;
    logic [COL_W-1:0]   cur_col_q, cur_col_d, sel_col_q, sel_col_d, sec_col_q, sec_col_d;
    logic               sel_valid_q, sel_valid_d;
    logic               phase_q, phase_d;
    logic [FLASH_W-1:0] cnt_q, cnt_d;
    logic [TYPE_W-1:0]  grid_q [ROWS][COLS];
    logic [TYPE_W-1:0]  grid_d [ROWS][COLS];
    logic               on_sel_s;
    logic               rd_in_range_s;

    // Cursor: one tile per edge, saturating, opposing edges cancel per axis.
    always_comb begin
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        if (up_e && !down_e && (cur_row_q != '0)) begin
            cur_row_d = cur_row_q - ROW_W'(1);
        end else if (down_e && !up_e && (cur_row_q != ROW_W'(ROWS - 1))) begin
            cur_row_d = cur_row_q + ROW_W'(1);
        end else begin
            cur_row_d = cur_row_q;
        end
        if (left_e && !right_e && (cur_col_q != '0)) begin
            cur_col_d = cur_col_q - COL_W'(1);
        end else if (right_e && !left_e && (cur_col_q != COL_W'(COLS - 1))) begin
            cur_col_d = cur_col_q + COL_W'(1);
        end else begin
            cur_col_d = cur_col_q;
        end
    end

    // Click acts on the pre-move cursor, so compare against the registered value.
    assign on_sel_s = (cur_row_q == sel_row_q) && (cur_col_q == sel_col_q);

`ifdef TILE_GRID_ADJ_ONLY_EN
    logic adj_s;

    // Orthogonal adjacency (|dr|+|dc| == 1); one bit of headroom avoids wrap on +1.
    always_comb begin
        adj_s = ((cur_row_q == sel_row_q) &&
                 (({1'b0, cur_col_q} == {1'b0, sel_col_q} + (COL_W + 1)'(1)) ||
                  ({1'b0, sel_col_q} == {1'b0, cur_col_q} + (COL_W + 1)'(1)))) ||
                ((cur_col_q == sel_col_q) &&
                 (({1'b0, cur_row_q} == {1'b0, sel_row_q} + (ROW_W + 1)'(1)) ||
                  ({1'b0, sel_row_q} == {1'b0, cur_row_q} + (ROW_W + 1)'(1))));
    end
`endif

    // Select/swap FSM, flash timer and grid write.
    always_comb begin
        state_d     = state_q;
        sel_valid_d = sel_valid_q;
        sel_row_d   = sel_row_q;
        sel_col_d   = sel_col_q;
        sec_row_d   = sec_row_q;
        sec_col_d   = sec_col_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        grid_d      = grid_q;

        // Flash timer runs only while a tile is selected.
        if (sel_valid_q) begin
            if (cnt_q == FLASH_W'(FLASH_DIV - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + FLASH_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (click_e) begin
                    state_d     = ST_SEL;
                    sel_valid_d = 1'b1;
                    sel_row_d   = cur_row_q;
                    sel_col_d   = cur_col_q;
                    cnt_d       = '0;
                    phase_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (!click_e) begin
                    state_d = ST_SEL;
                end else if (on_sel_s) begin
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
`ifdef TILE_GRID_ADJ_ONLY_EN
                end else if (!adj_s) begin
                    state_d   = ST_SEL;
                    sel_row_d = cur_row_q;
                    sel_col_d = cur_col_q;
                    cnt_d     = '0;
                    phase_d   = 1'b0;
`endif
                end else begin
                    state_d     = ST_SWAP;
                    sel_valid_d = 1'b0;
                    sec_row_d   = cur_row_q;
                    sec_col_d   = cur_col_q;
                end
            end
            ST_SWAP: begin
                grid_d[sel_row_q][sel_col_q] = grid_q[sec_row_q][sec_col_q];
                grid_d[sec_row_q][sec_col_q] = grid_q[sel_row_q][sel_col_q];
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                sel_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset reloads the grid pattern and drops any selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_row_q   <= ROW_W'(ROWS / 2);
            cur_col_q   <= COL_W'(COLS / 2);
            sel_valid_q <= 1'b0;
            sel_row_q   <= '0;
            sel_col_q   <= '0;
            sec_row_q   <= '0;
            sec_col_q   <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    grid_q[r][c] <= TYPE_W'(init_type(r, c, COLS, NUM_TYPES));
                end
            end
        end else begin
            state_q     <= state_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            sel_valid_q <= sel_valid_d;
            sel_row_q   <= sel_row_d;
            sel_col_q   <= sel_col_d;
            sec_row_q   <= sec_row_d;
            sec_col_q   <= sec_col_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            grid_q      <= grid_d;
        end
    end

    // Renderer read port; coordinates past the grid edge read as type 0, not blank.
    always_comb begin
        rd_in_range_s = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
        if (rd_in_range_s) begin
            rd_type = grid_q[rd_row][rd_col];
        end else begin
            rd_type = '0;
        end
        rd_blank = sel_valid_q & phase_q & rd_in_range_s &
                   (rd_row == sel_row_q) & (rd_col == sel_col_q);
    end

    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;
    assign sel_valid = sel_valid_q;
    assign sel_row   = sel_row_q;
    assign sel_col   = sel_col_q;
    assign swap_done = (state_q == ST_SWAP);

endmodule

// File: tb/tb_tile_grid_ctrl.sv
// Directed bench for tile_grid_ctrl on a 3x3 grid, 4 types, FLASH_DIV=4.
module tb_tile_grid_ctrl;
    import tile_grid_pkg::*;

    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_CLICK = 5'b10000;

    logic             clk;
    logic             rst_n;
    logic [4:0]       btns;
    logic [ROW_W-1:0] rd_row, cur_row, sel_row;
    logic [COL_W-1:0] rd_col, cur_col, sel_col;
    logic [1:0]       rd_type;
    logic             rd_blank, sel_valid, swap_done;

    int checks   = 0;
    int failures = 0;

    tile_grid_ctrl #(
        .ROWS(3), .COLS(3), .TYPE_W(2), .NUM_TYPES(4), .FLASH_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]),
        .btn_right(btns[3]), .btn_click(btns[4]),
        .rd_row(rd_row), .rd_col(rd_col), .rd_type(rd_type), .rd_blank(rd_blank),
        .cur_row(cur_row), .cur_col(cur_col),
        .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
        .swap_done(swap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        btns  = 5'b00000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        btns = m;
        @(negedge clk);
        btns = 5'b00000;
        @(negedge clk);
    endtask

    task automatic read_cell(input int r, input int c, output logic [1:0] t, output logic b);
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        #1;
        t = rd_type;
        b = rd_blank;
    endtask

    task automatic test_reset();
        int exp_pat [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic [1:0] t;
        logic b;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                read_cell(r, c, t, b);
                checks++;
                if (t !== 2'(exp_pat[r * 3 + c]) || b !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_cell(%0d,%0d) got type=%0d blank=%0b exp type=%0d blank=0",
                             r, c, t, b, exp_pat[r * 3 + c]);
                end
            end
        end
        checks++;
        if (cur_row !== 2'd1 || cur_col !== 2'd1 || sel_valid !== 1'b0 || swap_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got cur=(%0d,%0d) sel_valid=%0b swap_done=%0b exp cur=(1,1) 0 0",
                     cur_row, cur_col, sel_valid, swap_done);
        end
        read_cell(3, 0, t, b);
        checks++;
        if (t !== 2'd0 || b !== 1'b0) begin
            failures++;
            $display("FAIL oob_row got type=%0d blank=%0b exp 0 0", t, b);
        end
        read_cell(1, 3, t, b);
        checks++;
        if (t !== 2'd0 || b !== 1'b0) begin
            failures++;
            $display("FAIL oob_col got type=%0d blank=%0b exp 0 0", t, b);
        end
    endtask

    task automatic test_cursor();
        apply_reset();
        @(negedge clk);
        btns = B_UP;
        repeat (10) @(negedge clk);
        btns = 5'b00000;
        @(negedge clk);
        checks++;
        if (cur_row !== 2'd0) begin
            failures++;
            $display("FAIL hold_up got row=%0d exp row=0", cur_row);
        end
        press(B_UP);
        press(B_UP);
        checks++;
        if (cur_row !== 2'd0) begin
            failures++;
            $display("FAIL sat_top got row=%0d exp row=0", cur_row);
        end
        @(negedge clk);
        btns = B_DOWN;
        repeat (10) @(negedge clk);
        btns = 5'b00000;
        @(negedge clk);
        checks++;
        if (cur_row !== 2'd1) begin
            failures++;
            $display("FAIL hold_down_once got row=%0d exp row=1", cur_row);
        end
        press(B_UP | B_DOWN);
        checks++;
        if (cur_row !== 2'd1) begin
            failures++;
            $display("FAIL up_down_cancel got row=%0d exp row=1", cur_row);
        end
        press(B_DOWN);
        press(B_DOWN);
        checks++;
        if (cur_row !== 2'd2) begin
            failures++;
            $display("FAIL sat_bottom got row=%0d exp row=2", cur_row);
        end
        press(B_RIGHT);
        press(B_RIGHT);
        checks++;
        if (cur_col !== 2'd2) begin
            failures++;
            $display("FAIL sat_right got col=%0d exp col=2", cur_col);
        end
        press(B_LEFT);
        press(B_LEFT);
        press(B_LEFT);
        checks++;
        if (cur_col !== 2'd0) begin
            failures++;
            $display("FAIL sat_left got col=%0d exp col=0", cur_col);
        end
        press(B_UP | B_RIGHT);
        checks++;
        if (cur_row !== 2'd1 || cur_col !== 2'd1) begin
            failures++;
            $display("FAIL diag_move got (%0d,%0d) exp (1,1)", cur_row, cur_col);
        end
        press(B_LEFT | B_RIGHT);
        checks++;
        if (cur_col !== 2'd1 || sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL left_right_cancel got col=%0d sel_valid=%0b exp col=1 sel_valid=0",
                     cur_col, sel_valid);
        end
    endtask

    task automatic test_swap();
        logic [1:0] t0, t1, t2;
        logic b;
        apply_reset();
        press(B_UP);
        press(B_LEFT);
        press(B_CLICK);
        checks++;
        if (sel_valid !== 1'b1 || sel_row !== 2'd0 || sel_col !== 2'd0) begin
            failures++;
            $display("FAIL first_select got valid=%0b sel=(%0d,%0d) exp 1 (0,0)",
                     sel_valid, sel_row, sel_col);
        end
        press(B_RIGHT);
        @(negedge clk);
        btns = B_CLICK;
        @(negedge clk);
        read_cell(0, 0, t0, b);
        checks++;
        if (swap_done !== 1'b1 || sel_valid !== 1'b0 || t0 !== 2'd0) begin
            failures++;
            $display("FAIL swap_cycle got swap_done=%0b sel_valid=%0b cell00=%0d exp 1 0 0",
                     swap_done, sel_valid, t0);
        end
        btns = 5'b00000;
        @(negedge clk);
        read_cell(0, 0, t0, b);
        read_cell(0, 1, t1, b);
        read_cell(0, 2, t2, b);
        checks++;
        if (swap_done !== 1'b0 || t0 !== 2'd1 || t1 !== 2'd0 || t2 !== 2'd2) begin
            failures++;
            $display("FAIL swap_result got swap_done=%0b cells=%0d,%0d,%0d exp 0 1,0,2",
                     swap_done, t0, t1, t2);
        end
        @(negedge clk);
        checks++;
        if (swap_done !== 1'b0 || sel_valid !== 1'b0 || cur_row !== 2'd0 || cur_col !== 2'd1) begin
            failures++;
            $display("FAIL after_swap got swap_done=%0b sel_valid=%0b cur=(%0d,%0d) exp 0 0 (0,1)",
                     swap_done, sel_valid, cur_row, cur_col);
        end
    endtask

    task automatic test_flash();
        logic [1:0] t;
        logic b_sel, b_other;
        logic exp_b;
        apply_reset();
        press(B_DOWN);
        press(B_RIGHT);
        @(negedge clk);
        btns = B_CLICK;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btns = 5'b00000;
            read_cell(2, 2, t, b_sel);
            read_cell(2, 1, t, b_other);
            exp_b = ((i / 4) % 2) == 1;
            checks++;
            if (b_sel !== exp_b || b_other !== 1'b0) begin
                failures++;
                $display("FAIL flash_cycle%0d got blank22=%0b blank21=%0b exp %0b 0",
                         i, b_sel, b_other, exp_b);
            end
        end
    endtask

    task automatic test_deselect();
        int exp_pat [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic [1:0] t;
        logic b;
        int bad;
        apply_reset();
        press(B_CLICK);
        @(negedge clk);
        btns = B_CLICK;
        @(negedge clk);
        checks++;
        if (sel_valid !== 1'b0 || swap_done !== 1'b0) begin
            failures++;
            $display("FAIL deselect got sel_valid=%0b swap_done=%0b exp 0 0", sel_valid, swap_done);
        end
        btns = 5'b00000;
        @(negedge clk);
        checks++;
        if (swap_done !== 1'b0) begin
            failures++;
            $display("FAIL deselect_no_swap got swap_done=%0b exp 0", swap_done);
        end
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            read_cell(k / 3, k % 3, t, b);
            if (t !== 2'(exp_pat[k])) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL deselect_grid got %0d changed cells exp 0", bad);
        end
    endtask

    task automatic test_nonadjacent_reset();
        logic [1:0] t01, t22;
        logic b;
        apply_reset();
        press(B_UP);
        press(B_CLICK);
        press(B_DOWN);
        press(B_DOWN);
        press(B_RIGHT);
        @(negedge clk);
        btns = B_CLICK;
        @(negedge clk);
        btns = 5'b00000;
`ifdef TILE_GRID_ADJ_ONLY_EN
        checks++;
        if (swap_done !== 1'b0 || sel_valid !== 1'b1 || sel_row !== 2'd2 || sel_col !== 2'd2) begin
            failures++;
            $display("FAIL far_click_moves_sel got swap_done=%0b valid=%0b sel=(%0d,%0d) exp 0 1 (2,2)",
                     swap_done, sel_valid, sel_row, sel_col);
        end
        @(negedge clk);
        read_cell(0, 1, t01, b);
        read_cell(2, 2, t22, b);
        checks++;
        if (t01 !== 2'd1 || t22 !== 2'd0) begin
            failures++;
            $display("FAIL far_click_grid got cells=%0d,%0d exp 1,0", t01, t22);
        end
`else
        checks++;
        if (swap_done !== 1'b1) begin
            failures++;
            $display("FAIL far_swap_pulse got swap_done=%0b exp 1", swap_done);
        end
        @(negedge clk);
        read_cell(0, 1, t01, b);
        read_cell(2, 2, t22, b);
        checks++;
        if (t01 !== 2'd0 || t22 !== 2'd1) begin
            failures++;
            $display("FAIL far_swap_grid got cells=%0d,%0d exp 0,1", t01, t22);
        end
        press(B_CLICK);
`endif
        checks++;
        if (sel_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_sel got sel_valid=%0b exp 1", sel_valid);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        read_cell(0, 1, t01, b);
        read_cell(2, 2, t22, b);
        checks++;
        if (sel_valid !== 1'b0 || swap_done !== 1'b0 || cur_row !== 2'd1 || cur_col !== 2'd1 ||
            sel_row !== 2'd0 || sel_col !== 2'd0 || t01 !== 2'd1 || t22 !== 2'd0 || b !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got valid=%0b swap=%0b cur=(%0d,%0d) sel=(%0d,%0d) cells=%0d,%0d blank=%0b exp 0 0 (1,1) (0,0) 1,0 0",
                     sel_valid, swap_done, cur_row, cur_col, sel_row, sel_col, t01, t22, b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        btns   = 5'b00000;
        rd_row = '0;
        rd_col = '0;
        test_reset();
        test_cursor();
        test_swap();
        test_flash();
        test_deselect();
        test_nonadjacent_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
